// File: rtl/song_player_pkg.sv
// rtl/song_player_pkg.sv - opcodes, FSM states and END detection for song_player
package song_player_pkg;

    localparam logic [1:0] OP_NOTE  = 2'b00;
    localparam logic [1:0] OP_LIGHT = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        FETCH  = S_FETCH,
        DECODE = S_DECODE,
        ISSUE  = S_ISSUE
    } state_t;

    // END is the all-ones word over the low 'width' bits of a zero-extended command.
    function automatic logic is_end(input logic [31:0] cmd, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < width && !cmd[i]) all_ones = 1'b0;
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/song_player_btn_sync.sv
// rtl/song_player_btn_sync.sv - two-flop synchroniser, resets to released (all ones)
module btn_sync #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/song_player.sv
// rtl/song_player.sv - song ROM walker dispatching NOTE commands over valid/ready
module song_player
    import song_player_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int CMD_W    = 12,
    parameter int N_SONGS  = 2,
    parameter int N_LIGHTS = 4,
    parameter logic [N_SONGS*ADDR_W-1:0] SONG_BASE = '0,
    localparam int IDX_W = (N_SONGS > 1) ? $clog2(N_SONGS) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_SONGS-1:0]  btn_n,
    input  logic                stop_n,
    input  logic                pause,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [CMD_W-1:0]    rom_cmd,
    output logic [CMD_W-1:0]    seq_cmd,
    output logic                seq_valid,
    input  logic                seq_ready,
    output logic                playing,
    output logic [IDX_W-1:0]    song_idx,
    output logic [N_LIGHTS-1:0] lights_n
);

    localparam int LW = $clog2(N_LIGHTS);

    state_t             state;
    logic [N_SONGS:0]   sync;
    logic [N_SONGS-1:0] btn_s;
    logic               abort;
    logic               start;
    logic [IDX_W-1:0]   start_idx;
    logic [ADDR_W-1:0]  start_base;
    logic [ADDR_W-1:0]  loop_base;
    logic [1:0]         opcode;
    logic               cmd_end;
    logic [N_LIGHTS-1:0] light_pattern;

    btn_sync #(.W(N_SONGS + 1)) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     ({stop_n, btn_n}),
        .q     (sync)
    );

    assign abort = ~sync[N_SONGS];
    assign btn_s = sync[N_SONGS-1:0];

    // Scan downwards so the lowest pressed index is the one left standing.
    always_comb begin
        start     = 1'b0;
        start_idx = '0;
        for (int i = N_SONGS - 1; i >= 0; i--) begin
            if (!btn_s[i]) begin
                start     = 1'b1;
                start_idx = IDX_W'(i);
            end
        end
    end

    assign start_base    = SONG_BASE[int'(start_idx)*ADDR_W +: ADDR_W];
    assign loop_base     = SONG_BASE[int'(song_idx)*ADDR_W +: ADDR_W];
    assign opcode        = rom_cmd[CMD_W-1 -: 2];
    assign cmd_end       = is_end(32'(rom_cmd), CMD_W);
    assign light_pattern = ~(N_LIGHTS'(1) << rom_cmd[LW-1:0]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            rom_addr  <= '0;
            seq_cmd   <= '0;
            seq_valid <= 1'b0;
            playing   <= 1'b0;
            song_idx  <= '0;
            lights_n  <= '1;
        end else if (abort) begin
            state     <= IDLE;
            seq_valid <= 1'b0;
            playing   <= 1'b0;
            lights_n  <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= start_base;
                        song_idx <= start_idx;
                        playing  <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!pause) state <= DECODE;
                end
                DECODE: begin
                    if (cmd_end) begin
                        if (loop_en) begin
                            rom_addr <= loop_base;
                            state    <= FETCH;
                        end else begin
                            playing  <= 1'b0;
                            lights_n <= '1;
                            state    <= IDLE;
                        end
                    end else begin
                        case (opcode)
                            OP_NOTE: begin
                                seq_cmd   <= rom_cmd;
                                seq_valid <= 1'b1;
                                lights_n  <= '1;
                                state     <= ISSUE;
                            end
                            OP_LIGHT: begin
                                lights_n <= light_pattern;
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end
                            OP_JUMP: begin
                                rom_addr <= rom_cmd[ADDR_W-1:0];
                                state    <= FETCH;
                            end
                            default: begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= FETCH;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (seq_ready) begin
                        seq_valid <= 1'b0;
                        rom_addr  <= rom_addr + ADDR_W'(1);
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - directed table and sequence checks for song_player
module tb_song_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  btn_n;
    logic        stop_n;
    logic        pause;
    logic        loop_en;
    logic [7:0]  rom_addr;
    logic [11:0] rom_cmd;
    logic [11:0] seq_cmd;
    logic        seq_valid;
    logic        seq_ready;
    logic        playing;
    logic        song_idx;
    logic [3:0]  lights_n;

    logic [11:0] rom [256];

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  btn;
        logic [7:0]  addr;
        logic        valid;
        logic [11:0] cmd;
        logic        play;
        logic        idx;
        logic [3:0]  lights;
    } vec_t;

    vec_t tbl [11];

    song_player #(
        .ADDR_W    (8),
        .CMD_W     (12),
        .N_SONGS   (2),
        .N_LIGHTS  (4),
        .SONG_BASE (16'h4010)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .btn_n     (btn_n),
        .stop_n    (stop_n),
        .pause     (pause),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_cmd   (rom_cmd),
        .seq_cmd   (seq_cmd),
        .seq_valid (seq_valid),
        .seq_ready (seq_ready),
        .playing   (playing),
        .song_idx  (song_idx),
        .lights_n  (lights_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_cmd <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] pattern);
        btn_n = pattern;
        repeat (3) step();
        btn_n = 2'b11;
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget, input string name);
        int k = 0;
        while (rom_addr !== a && k < budget) begin
            step();
            k++;
        end
        chk(name, {24'b0, rom_addr}, {24'b0, a});
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (seq_valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk(name, {31'b0, seq_valid}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (playing !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        chk(name, {31'b0, playing}, 32'd0);
    endtask

    function automatic logic [31:0] outs_now();
        return {5'b0, rom_addr, seq_valid, seq_cmd, playing, song_idx, lights_n};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int stable;
        for (int i = 0; i < 256; i++) rom[i] = 12'hC00;
        rom[8'h00] = 12'hFFF;
        rom[8'h05] = 12'hFFF;
        rom[8'h10] = 12'h402;
        rom[8'h11] = 12'h123;
        rom[8'h12] = 12'hFFF;
        rom[8'h40] = 12'h8FF;
        rom[8'hFF] = 12'h805;

        //            btn    addr   v  cmd     p  i  lights
        tbl[0]  = '{2'b00, 8'h00, 0, 12'h000, 0, 0, 4'hF};
        tbl[1]  = '{2'b00, 8'h00, 0, 12'h000, 0, 0, 4'hF};
        tbl[2]  = '{2'b11, 8'h10, 0, 12'h000, 1, 0, 4'hF};
        tbl[3]  = '{2'b11, 8'h10, 0, 12'h000, 1, 0, 4'hF};
        tbl[4]  = '{2'b11, 8'h11, 0, 12'h000, 1, 0, 4'hB};
        tbl[5]  = '{2'b11, 8'h11, 0, 12'h000, 1, 0, 4'hB};
        tbl[6]  = '{2'b11, 8'h11, 1, 12'h123, 1, 0, 4'hF};
        tbl[7]  = '{2'b11, 8'h12, 0, 12'h123, 1, 0, 4'hF};
        tbl[8]  = '{2'b11, 8'h12, 0, 12'h123, 1, 0, 4'hF};
        tbl[9]  = '{2'b11, 8'h12, 0, 12'h123, 0, 0, 4'hF};
        tbl[10] = '{2'b11, 8'h12, 0, 12'h123, 0, 0, 4'hF};

        rst_n = 1'b0; btn_n = 2'b11; stop_n = 1'b1; pause = 1'b0;
        loop_en = 1'b0; seq_ready = 1'b1;
        step();
        step();
        chk("reset_values", outs_now(), {5'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 4'hF});
        rst_n = 1'b1;

        // Both buttons pressed together: song 0 (base 0x10) plays LIGHT 2, NOTE 0x123, END.
        for (int k = 0; k < 11; k++) begin
            btn_n = tbl[k].btn;
            step();
            chk($sformatf("table_%0d", k), outs_now(),
                {5'b0, tbl[k].addr, tbl[k].valid, tbl[k].cmd, tbl[k].play, tbl[k].idx, tbl[k].lights});
        end

        // NOTE held with seq_ready low for 20 cycles.
        seq_ready = 1'b0;
        press(2'b10);
        wait_valid(20, "backpressure_valid");
        stable = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (seq_valid === 1'b1 && seq_cmd === 12'h123 && rom_addr === 8'h11) stable++;
        end
        chk("backpressure_stable", stable, 20);
        seq_ready = 1'b1;
        step();
        chk("handshake_addr", {24'b0, rom_addr}, 32'h12);
        chk("handshake_valid", {31'b0, seq_valid}, 32'd0);
        wait_idle(20, "backpressure_end");

        // Song 1: JUMP 0xFF, then JUMP 0x05 at 0xFF.
        press(2'b01);
        chk("song1_idx", {31'b0, song_idx}, 32'd1);
        wait_addr(8'hFF, 20, "jump_to_ff");
        step();
        step();
        chk("jump_from_ff", {24'b0, rom_addr}, 32'h05);
        wait_idle(20, "jump_end");

        // NOTE at 0xFF: the increment wraps to 0x00.
        rom[8'hFF] = 12'h0AB;
        press(2'b01);
        wait_addr(8'hFF, 20, "wrap_reach_ff");
        step();
        step();
        chk("wrap_note", {19'b0, seq_valid, seq_cmd}, {19'b0, 1'b1, 12'h0AB});
        step();
        chk("wrap_addr", {24'b0, rom_addr}, 32'h00);
        wait_idle(20, "wrap_end");

        // Loop on END, then abort during ISSUE.
        loop_en = 1'b1;
        press(2'b10);
        wait_addr(8'h12, 30, "loop_reach_end");
        step();
        step();
        chk("loop_restart", {23'b0, playing, rom_addr}, {23'b0, 1'b1, 8'h10});
        seq_ready = 1'b0;
        wait_valid(30, "loop_issue");
        stop_n = 1'b0;
        repeat (3) step();
        chk("abort_outputs", {26'b0, playing, seq_valid, lights_n}, {26'b0, 1'b0, 1'b0, 4'hF});
        stop_n = 1'b1; loop_en = 1'b0; seq_ready = 1'b1;
        repeat (3) step();
        chk("abort_stays_idle", {31'b0, playing}, 32'd0);

        // Pause freezes FETCH; then asynchronous reset during ISSUE.
        pause = 1'b1;
        press(2'b10);
        stable = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rom_addr === 8'h10 && playing === 1'b1) stable++;
        end
        chk("pause_hold", stable, 10);
        pause = 1'b0;
        step();
        step();
        chk("pause_resume", {24'b0, rom_addr}, 32'h11);
        seq_ready = 1'b0;
        wait_valid(20, "reset_issue");
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs_now(), {5'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 4'hF});
        step();
        rst_n = 1'b1;
        seq_ready = 1'b1;
        repeat (4) step();
        chk("post_reset_idle", {23'b0, playing, rom_addr}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
